// File: rtl/adder_tree_pkg.sv
// Shared types and default sizing for the adder-tree sequencer slice.
package adder_tree_pkg;

  localparam int DEF_WIDTH      = 17;
  localparam int DEF_LANES      = 32;
  localparam int DEF_TREE_LAT   = 3;
  localparam int DEF_MAX_CHUNKS = 8;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    DRAIN  = 2'd1,
    HOLD   = 2'd2
  } state_t;

  typedef struct packed {
    logic v;
    logic last;
  } tag_t;

  localparam tag_t TAG_IDLE = '{v: 1'b0, last: 1'b0};

endpackage

// File: rtl/adder_tree_seq_ctrl_tag_pipe.sv
// Fixed-depth shift register of chunk tags that rides alongside the tree pipeline.
module tag_pipe
  import adder_tree_pkg::*;
#(
  parameter int DEPTH = DEF_TREE_LAT
) (
  input  logic clk,
  input  logic reset,
  input  tag_t din,
  output tag_t dout
);

  tag_t stages [DEPTH];

  // Shift every edge; reset empties the pipe so stale tree sums carry no tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= TAG_IDLE;
      end
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/adder_tree_seq_ctrl.sv
// Streams LANES-wide chunks into an external pipelined adder tree, follows them
// with tags, accumulates the per-chunk sums and presents one total per vector.
module adder_tree_seq_ctrl
  import adder_tree_pkg::*;
#(
  parameter  int WIDTH      = DEF_WIDTH,
  parameter  int LANES      = DEF_LANES,
  parameter  int TREE_LAT   = DEF_TREE_LAT,
  parameter  int MAX_CHUNKS = DEF_MAX_CHUNKS,
  localparam int CW         = $clog2(MAX_CHUNKS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data [LANES],
  input  logic                    in_last,
  output logic signed [WIDTH-1:0] tree_data [LANES],
  input  logic signed [WIDTH-1:0] tree_sum,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_sum,
  output logic [CW-1:0]           out_chunks,
  output logic                    out_trunc
);

  state_t                  state;
  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH-1:0] acc_next;
  logic [CW-1:0]           count;
  logic [CW-1:0]           sum_cnt;
  logic                    accept;
  logic                    at_limit;
  logic                    eff_last;
  tag_t                    tag_in;
  tag_t                    tag_q;
  tag_t                    tag_out;

  assign in_ready = (state == ACCEPT);
  assign accept   = in_valid && in_ready;
  assign at_limit = (count == CW'(MAX_CHUNKS - 1));
  assign eff_last = in_last || at_limit;
  assign tag_in   = accept ? '{v: 1'b1, last: eff_last} : TAG_IDLE;

  // The first summed chunk of a vector replaces whatever acc held before.
  assign acc_next = ((sum_cnt == '0) ? '0 : acc) + tree_sum;

  // Tree input register plus the tag stage that travels with it; bubbles feed zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= TAG_IDLE;
      for (int i = 0; i < LANES; i++) begin
        tree_data[i] <= '0;
      end
    end else begin
      tag_q <= tag_in;
      for (int i = 0; i < LANES; i++) begin
        tree_data[i] <= accept ? in_data[i] : '0;
      end
    end
  end

  // Tags emerge in the same cycle as the matching tree_sum.
  tag_pipe #(
    .DEPTH (TREE_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .din   (tag_q),
    .dout  (tag_out)
  );

  // Sequencer: accept chunks, drain the tree until the last tag, then hold the total.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ACCEPT;
      acc        <= '0;
      count      <= '0;
      sum_cnt    <= '0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_chunks <= '0;
      out_trunc  <= 1'b0;
    end else begin
      if (tag_out.v) begin
        acc     <= acc_next;
        sum_cnt <= sum_cnt + CW'(1);
      end
      case (state)
        ACCEPT: begin
          if (accept) begin
            count <= count + CW'(1);
            if (eff_last) begin
              out_trunc <= !in_last && at_limit;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (tag_out.v && tag_out.last) begin
            out_sum    <= acc_next;
            out_chunks <= sum_cnt + CW'(1);
            out_valid  <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            sum_cnt   <= '0;
            state     <= ACCEPT;
          end
        end
        default: begin
          state <= ACCEPT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_tree_seq_ctrl.sv
// Bench for adder_tree_seq_ctrl: behavioural tree, vector-level reference model,
// scoreboard queue and an independent output monitor.
module tb_adder_tree_seq_ctrl;
  import adder_tree_pkg::*;

  localparam int WIDTH      = DEF_WIDTH;
  localparam int LANES      = DEF_LANES;
  localparam int TREE_LAT   = DEF_TREE_LAT;
  localparam int MAX_CHUNKS = DEF_MAX_CHUNKS;
  localparam int CW         = $clog2(MAX_CHUNKS + 1);

  typedef struct {
    logic signed [WIDTH-1:0] sum;
    int                      chunks;
    bit                      trunc;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data [LANES];
  logic                    in_last;
  logic signed [WIDTH-1:0] tree_data [LANES];
  logic signed [WIDTH-1:0] tree_sum;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic signed [WIDTH-1:0] out_sum;
  logic [CW-1:0]           out_chunks;
  logic                    out_trunc;

  logic signed [WIDTH-1:0] chunk_buf [LANES];
  logic signed [WIDTH-1:0] tree_pipe [TREE_LAT];

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_acc_cyc = 0;
  int   hs_cyc      = -10;
  longint cur_sum   = 0;
  int   cur_n       = 0;
  bit   hold_ready  = 1'b0;
  bit   rand_ready  = 1'b0;
  bit   prev_valid  = 1'b0;
  bit   prev_ready  = 1'b0;

  adder_tree_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .tree_data  (tree_data),
    .tree_sum   (tree_sum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_chunks (out_chunks),
    .out_trunc  (out_trunc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural tree: plain lane sum delayed by TREE_LAT edges, no reset, no valid.
  always @(posedge clk) begin
    longint t;
    t = 0;
    for (int i = 0; i < LANES; i++) t += longint'(tree_data[i]);
    tree_pipe[0] <= WIDTH'(t);
    for (int i = 1; i < TREE_LAT; i++) tree_pipe[i] <= tree_pipe[i-1];
  end
  assign tree_sum = tree_pipe[TREE_LAT-1];

  // Downstream ready: held low on demand, else random or always high.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hold_ready) out_ready = 1'b0;
      else if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Drive one chunk (from chunk_buf) after a gap, wait for the handshake, update the model.
  task automatic applyStimulus(input bit last, input int gap);
    bit waited;
    int guard;
    int acc_cyc;
    bit done;
    exp_t e;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = chunk_buf;
    in_last  = last;
    in_valid = 1'b1;
    waited   = 1'b0;
    guard    = 0;
    while (!in_ready && guard < 300) begin
      waited = 1'b1;
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 0, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "[TB] controller never became ready");
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (waited) checkOutput("accept_after_handshake", acc_cyc, hs_cyc + 1);
    for (int i = 0; i < LANES; i++) cur_sum += longint'(chunk_buf[i]);
    cur_n++;
    done = last || (cur_n == MAX_CHUNKS);
    if (done) begin
      e.sum    = WIDTH'(cur_sum);
      e.chunks = cur_n;
      e.trunc  = !last && (cur_n == MAX_CHUNKS);
      sb.push_back(e);
      last_acc_cyc = acc_cyc;
      cur_sum = 0;
      cur_n   = 0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("in_ready_after_accept", in_ready, !done);
  endtask

  task automatic waitDrain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  // Monitor: every valid cycle must match the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid <= 1'b0;
      prev_ready <= 1'b0;
    end else begin
      if (prev_valid && !prev_ready) checkOutput("valid_held", out_valid, 1);
      if (out_valid) begin
        checkOutput("in_ready_while_valid", in_ready, 0);
        if (!prev_valid) checkOutput("latency", cyc - last_acc_cyc, TREE_LAT + 1);
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          checkOutput("out_sum", out_sum, sb[0].sum);
          checkOutput("out_chunks", out_chunks, sb[0].chunks);
          checkOutput("out_trunc", out_trunc, sb[0].trunc);
          if (out_ready) begin
            void'(sb.pop_front());
            hs_cyc = cyc + 1;
          end
        end
      end
      prev_valid <= out_valid;
      prev_ready <= out_ready;
    end
  end

  initial begin
    int n;
    int g;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < LANES; i++) in_data[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_sum", out_sum, 0);
    checkOutput("reset_out_chunks", out_chunks, 0);
    checkOutput("reset_out_trunc", out_trunc, 0);
    checkOutput("reset_tree_data", tree_data[0], 0);

    $display("[TB] single chunk 1..32");
    for (int i = 0; i < LANES; i++) chunk_buf[i] = WIDTH'(i + 1);
    applyStimulus(1'b1, 0);
    waitDrain();

    $display("[TB] two chunks +1 / -1 with gap");
    for (int i = 0; i < LANES; i++) chunk_buf[i] = WIDTH'(1);
    applyStimulus(1'b0, 0);
    for (int i = 0; i < LANES; i++) chunk_buf[i] = -WIDTH'(1);
    applyStimulus(1'b1, 2);
    waitDrain();

    $display("[TB] wrap-around chunk");
    for (int i = 0; i < LANES; i++) chunk_buf[i] = WIDTH'(65535);
    applyStimulus(1'b1, 0);
    waitDrain();

    $display("[TB] backpressure");
    hold_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < LANES; i++) chunk_buf[i] = WIDTH'($urandom);
    applyStimulus(1'b1, 0);
    g = 0;
    while (!out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    checkOutput("bp_valid_seen", out_valid, 1);
    repeat (5) @(negedge clk);
    hold_ready = 1'b0;
    for (int i = 0; i < LANES; i++) chunk_buf[i] = WIDTH'(i + 1);
    applyStimulus(1'b1, 0);
    waitDrain();

    $display("[TB] truncation at MAX_CHUNKS");
    for (int i = 0; i < LANES; i++) chunk_buf[i] = WIDTH'(1);
    for (int c = 0; c < MAX_CHUNKS + 1; c++) applyStimulus(1'b0, 0);
    for (int i = 0; i < LANES; i++) chunk_buf[i] = WIDTH'(2);
    applyStimulus(1'b1, 0);
    waitDrain();

    $display("[TB] reset during drain");
    for (int i = 0; i < LANES; i++) chunk_buf[i] = WIDTH'($urandom);
    applyStimulus(1'b0, 0);
    for (int i = 0; i < LANES; i++) chunk_buf[i] = WIDTH'($urandom);
    applyStimulus(1'b1, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    cur_sum = 0;
    cur_n   = 0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", in_ready, 1);
    checkOutput("post_reset_out_valid", out_valid, 0);
    for (int i = 0; i < LANES; i++) chunk_buf[i] = WIDTH'(i + 1);
    applyStimulus(1'b1, 0);
    waitDrain();

    $display("[TB] randomized vectors");
    rand_ready = 1'b1;
    for (int v = 0; v < 25; v++) begin
      n = $urandom_range(1, MAX_CHUNKS + 2);
      for (int c = 0; c < n; c++) begin
        for (int i = 0; i < LANES; i++) chunk_buf[i] = WIDTH'($urandom);
        applyStimulus(c == n - 1, $urandom_range(0, 2));
      end
    end
    waitDrain();
    rand_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_tree_seq_ctrl.md
Name: adder_tree_seq_ctrl

Overview:
- Sequencer wrapped around a pipelined LANES-wide adder-tree instance. The tree has a fixed latency TREE_LAT and no internal valid.
- Accepts a long signed vector as a stream of LANES-wide chunks over a valid/ready handshake and pushes each accepted chunk into the tree.
- Tracks in-flight chunks with a tag pipeline and accumulates the partial sums.
- Presents one total per vector on a valid/ready output. Sits between the Batchnorm/JetTagging feature buffers and downstream scaling logic.

Parameters:
- WIDTH, 17: signed data, tree-sum and accumulator width.
- LANES, 32: tree input count (chunk size).
- TREE_LAT, 3: clock edges from tree input register to a valid tree_sum (3 for a 32-input 4-ary tree).
- MAX_CHUNKS, 8: maximum chunks per vector.
- CW, $clog2(MAX_CHUNKS+1): chunk-count width (derived localparam).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  chunk valid
- in_ready  out  1  controller can accept a chunk
- in_data  in  WIDTH x LANES (signed, unpacked [LANES])  chunk lanes
- in_last  in  1  final chunk of the vector
- tree_data  out  WIDTH x LANES (signed)  registered tree inputs
- tree_sum  in  WIDTH (signed)  tree root output
- out_valid  out  1  total valid
- out_ready  in  1  downstream accepts total
- out_sum  out  WIDTH (signed)  vector total
- out_chunks  out  CW  chunks summed for this vector
- out_trunc  out  1  vector was force-terminated at MAX_CHUNKS

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=ACCEPT, tree_data all 0, tags 0, acc=0, count=0, out_valid=0, out_sum=0, out_chunks=0, out_trunc=0.
- Mid-operation reset discards in-flight chunks. The first post-reset tree_sum values carry no tag and are ignored.
- Accept rule: a chunk is accepted on an edge where in_valid && in_ready. in_ready = (state==ACCEPT), combinational from state only.
- Tree feed, every edge: tree_data <= accepted ? in_data : 0. Bubbles feed zeros.
- Tag pipeline, depth TREE_LAT: entry {v, last} shifts every edge.
  - Pushed {1, eff_last} on accept, else {0, 0}.
  - eff_last = in_last || (count == MAX_CHUNKS-1).
- Tag alignment: the tag emerging at the pipe output is aligned with tree_sum in that same cycle. The tag is pushed at the same edge as tree_data and emerges TREE_LAT edges later.
- Accumulate on emerging tag v=1:
  - acc <= (first ? 0 : acc) + tree_sum, where first = (no prior chunk of this vector summed).
  - Arithmetic is two's-complement modulo 2^WIDTH (wraps), with no saturation.
- count increments on each accept and resets to 0 when the vector completes.
- States:
  - ACCEPT: accept chunks. On accepting eff_last -> DRAIN. out_trunc is latched = !in_last && count==MAX_CHUNKS-1.
  - DRAIN: in_ready=0. When the emerging tag has last=1: out_sum <= acc_next, out_chunks <= chunks summed, out_valid <= 1, -> HOLD.
  - HOLD: out_valid=1, with out_sum/out_chunks/out_trunc stable. When out_ready is high: out_valid <= 0, acc/count cleared, -> ACCEPT.
- Latency: last chunk accepted at edge k -> out_valid is high after edge k+TREE_LAT+1. A single-chunk vector gives out_valid 4 edges after accept at defaults.
- Gaps: in_valid may drop between chunks. Bubbles inject zero tags, which are not accumulated.
- No overlap: the next vector is not accepted until the current total has been taken. in_data is ignored while in_ready=0.
- out_ready while out_valid=0 has no effect. Simultaneous reset and out_ready: reset wins.

Decomposition:
- Shared package adder_tree_pkg:
  - state enum {ACCEPT, DRAIN, HOLD}
  - tag struct {logic v; logic last;}
  - default WIDTH/LANES/TREE_LAT constants
- Sub-module tag_pipe: parameterised TREE_LAT-deep shift register of tags with synchronous reset.
- The tree itself is instantiated by the parent, not inside this block. The bench instantiates tree + controller together.

Test Plan:
- Single chunk, lanes 1..32, in_last=1, out_ready=1 -> out_valid after 4 edges; out_sum=528, out_chunks=1, out_trunc=0.
- Two chunks (all +1 then all -1, in_valid gap of 2 cycles between them) -> out_sum=0, out_chunks=2; in_ready=0 from the last accept until the handshake.
- Wrap: one chunk, all lanes 65535 -> out_sum=-32 (2097120 mod 2^17, signed).
- Backpressure: out_ready low for 5 cycles after out_valid -> out_sum/out_valid held stable, in_ready=0; the next vector is accepted on the cycle after out_ready=1.
- Truncation: 9 consecutive chunks of all 1, none with last -> after the 8th accept in_ready=0; out_sum=256, out_chunks=8, out_trunc=1. The 9th chunk is accepted only as the first chunk of the next vector.
- Reset asserted in DRAIN with 2 chunks in flight -> next cycle in_ready=1, out_valid=0. A following single chunk of lanes 1..32 yields 528, uncorrupted by the stale sums.
